// File: rtl/jtopl_mmr_banked.sv
// OPL register front end for 1 or 2 banks: timer/control decode, forwarded
// operator writes, status read, cen prescaler and write-busy timing.
// Optional: JTOPL_BUSY_DROP_EN discards writes that arrive while busy.
module jtopl_mmr_banked #(
  parameter int BANKS     = 1,
  parameter int DIV       = 16,
  parameter int BUSY_ADDR = 4,
  parameter int BUSY_DATA = 23
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cen,
  output logic             cen_div,
  input  logic [BANKS-1:0] addr,
  input  logic [7:0]       din,
  input  logic             write,
  input  logic             read,
  output logic [7:0]       dout,
  output logic             busy,
  output logic             irq_n,
  output logic [7:0]       value_A,
  output logic [7:0]       value_B,
  output logic             load_A,
  output logic             load_B,
  output logic             flagen_A,
  output logic             flagen_B,
  output logic             clr_flag_A,
  output logic             clr_flag_B,
  input  logic             flag_A,
  input  logic             flag_B,
  output logic             csm,
  output logic             nts,
  output logic             regop_wr,
  output logic [8:0]       regop_addr,
  output logic [7:0]       regop_din
);

  localparam int PW   = $clog2(DIV);
  localparam int BMAX = (BUSY_DATA > BUSY_ADDR) ? BUSY_DATA : BUSY_ADDR;
  localparam int BW   = (BMAX > 0) ? $clog2(BMAX + 1) : 1;

  logic [PW-1:0] pcnt_q, pcnt_d;
  logic [BW-1:0] busy_cnt_q, busy_cnt_d;
  logic [7:0]    sel_q, sel_d;
  logic          bank_q, bank_d;
  logic [7:0]    value_a_q, value_a_d, value_b_q, value_b_d;
  logic          load_a_q, load_a_d, load_b_q, load_b_d;
  logic          flagen_a_q, flagen_a_d, flagen_b_q, flagen_b_d;
  logic          clr_a_q, clr_a_d, clr_b_q, clr_b_d;
  logic          csm_q, csm_d, nts_q, nts_d;
  logic          regop_wr_q, regop_wr_d;
  logic [8:0]    regop_addr_q, regop_addr_d;
  logic [7:0]    regop_din_q, regop_din_d;
  logic [7:0]    dout_q, dout_d;
  logic          irq_q, irq_d;

  logic [1:0]    addr_ext;
  logic          bank_in, tick, wr_ok, wr_addr, wr_data, fwd;
  logic          st_a, st_b, irq_c;

  assign busy = (busy_cnt_q != '0);

`ifdef JTOPL_BUSY_DROP_EN
  assign wr_ok = write & ~busy;
`else
  assign wr_ok = write;
`endif

  always_comb begin
    addr_ext = '0;
    addr_ext[BANKS-1:0] = addr;
    bank_in = addr_ext[1] & (BANKS == 2);
    tick    = cen & (pcnt_q == PW'(DIV - 1));
    wr_addr = wr_ok & ~addr_ext[0];
    wr_data = wr_ok & addr_ext[0];
    st_a    = flag_A & flagen_a_q;
    st_b    = flag_B & flagen_b_q;
    irq_c   = st_a | st_b;

    pcnt_d       = pcnt_q;
    busy_cnt_d   = busy_cnt_q;
    sel_d        = sel_q;
    bank_d       = bank_q;
    value_a_d    = value_a_q;
    value_b_d    = value_b_q;
    load_a_d     = load_a_q;
    load_b_d     = load_b_q;
    flagen_a_d   = flagen_a_q;
    flagen_b_d   = flagen_b_q;
    clr_a_d      = clr_a_q;
    clr_b_d      = clr_b_q;
    csm_d        = csm_q;
    nts_d        = nts_q;
    regop_wr_d   = 1'b0;
    regop_addr_d = regop_addr_q;
    regop_din_d  = regop_din_q;
    dout_d       = dout_q;
    irq_d        = irq_c;
    fwd          = 1'b0;

    if (cen) pcnt_d = tick ? '0 : pcnt_q + PW'(1);

    // write reload has priority over the prescaled decrement
    if (wr_addr)                          busy_cnt_d = BW'(BUSY_ADDR);
    else if (wr_data)                     busy_cnt_d = BW'(BUSY_DATA);
    else if (tick && busy_cnt_q != '0)    busy_cnt_d = busy_cnt_q - BW'(1);

    if (tick) begin
      clr_a_d = 1'b0;
      clr_b_d = 1'b0;
    end

    if (wr_addr) begin
      sel_d  = din;
      bank_d = bank_in;
    end

    if (wr_data) begin
      if (bank_q) fwd = 1'b1;
      else begin
        case (sel_q)
          8'h02: value_a_d = din;
          8'h03: value_b_d = din;
          8'h04: begin
            if (din[7]) begin
              clr_a_d = 1'b1;
              clr_b_d = 1'b1;
            end else begin
              flagen_a_d = ~din[6];
              flagen_b_d = ~din[5];
              load_b_d   = din[1];
              load_a_d   = din[0];
            end
          end
          8'h08: begin
            csm_d = din[7];
            nts_d = din[6];
          end
          default: fwd = 1'b1;
        endcase
      end
    end

    if (fwd) begin
      regop_wr_d   = 1'b1;
      regop_addr_d = {bank_q, sel_q};
      regop_din_d  = din;
    end

    if (read && !addr_ext[0]) dout_d = {irq_c, st_a, st_b, 5'b0};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pcnt_q       <= '0;
      busy_cnt_q   <= '0;
      sel_q        <= '0;
      bank_q       <= 1'b0;
      value_a_q    <= '0;
      value_b_q    <= '0;
      load_a_q     <= 1'b0;
      load_b_q     <= 1'b0;
      flagen_a_q   <= 1'b1;
      flagen_b_q   <= 1'b1;
      clr_a_q      <= 1'b0;
      clr_b_q      <= 1'b0;
      csm_q        <= 1'b0;
      nts_q        <= 1'b0;
      regop_wr_q   <= 1'b0;
      regop_addr_q <= '0;
      regop_din_q  <= '0;
      dout_q       <= '0;
      irq_q        <= 1'b0;
    end else begin
      pcnt_q       <= pcnt_d;
      busy_cnt_q   <= busy_cnt_d;
      sel_q        <= sel_d;
      bank_q       <= bank_d;
      value_a_q    <= value_a_d;
      value_b_q    <= value_b_d;
      load_a_q     <= load_a_d;
      load_b_q     <= load_b_d;
      flagen_a_q   <= flagen_a_d;
      flagen_b_q   <= flagen_b_d;
      clr_a_q      <= clr_a_d;
      clr_b_q      <= clr_b_d;
      csm_q        <= csm_d;
      nts_q        <= nts_d;
      regop_wr_q   <= regop_wr_d;
      regop_addr_q <= regop_addr_d;
      regop_din_q  <= regop_din_d;
      dout_q       <= dout_d;
      irq_q        <= irq_d;
    end
  end

  assign cen_div    = tick;
  assign dout       = dout_q;
  assign irq_n      = ~irq_q;
  assign value_A    = value_a_q;
  assign value_B    = value_b_q;
  assign load_A     = load_a_q;
  assign load_B     = load_b_q;
  assign flagen_A   = flagen_a_q;
  assign flagen_B   = flagen_b_q;
  assign clr_flag_A = clr_a_q;
  assign clr_flag_B = clr_b_q;
  assign csm        = csm_q;
  assign nts        = nts_q;
  assign regop_wr   = regop_wr_q;
  assign regop_addr = regop_addr_q;
  assign regop_din  = regop_din_q;

endmodule

// File: tb/tb_jtopl_mmr_banked.sv
// Scoreboard bench for jtopl_mmr_banked (BANKS=2): reference model updated on
// each clock, monitor compares outputs and pops forwarded-write/status queues.
module tb_jtopl_mmr_banked;

  localparam int DIV = 16;
  localparam int BA  = 4;
  localparam int BD  = 23;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cen = 1'b0;
  logic       cen_div;
  logic [1:0] addr = '0;
  logic [7:0] din = '0;
  logic       write = 1'b0, read = 1'b0;
  logic [7:0] dout;
  logic       busy, irq_n;
  logic [7:0] value_A, value_B;
  logic       load_A, load_B, flagen_A, flagen_B, clr_flag_A, clr_flag_B;
  logic       flag_A = 1'b0, flag_B = 1'b0;
  logic       csm, nts, regop_wr;
  logic [8:0] regop_addr;
  logic [7:0] regop_din;

  jtopl_mmr_banked #(.BANKS(2), .DIV(DIV), .BUSY_ADDR(BA), .BUSY_DATA(BD)) dut (
    .clk(clk), .rst_n(rst_n), .cen(cen), .cen_div(cen_div), .addr(addr),
    .din(din), .write(write), .read(read), .dout(dout), .busy(busy),
    .irq_n(irq_n), .value_A(value_A), .value_B(value_B), .load_A(load_A),
    .load_B(load_B), .flagen_A(flagen_A), .flagen_B(flagen_B),
    .clr_flag_A(clr_flag_A), .clr_flag_B(clr_flag_B), .flag_A(flag_A),
    .flag_B(flag_B), .csm(csm), .nts(nts), .regop_wr(regop_wr),
    .regop_addr(regop_addr), .regop_din(regop_din)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // reference model: registers as plain variables, busy as remaining ticks
  int       pc = 0;
  int       m_busy = 0;
  bit [7:0] m_sel = 0;
  bit       m_bank = 0;
  bit [7:0] m_va = 0, m_vb = 0;
  bit       m_la = 0, m_lb = 0, m_fa = 1, m_fb = 1, m_ca = 0, m_cb = 0;
  bit       m_csm = 0, m_nts = 0, m_rw = 0, m_irq = 0;
  logic [16:0] rq[$];
  logic [7:0]  dq[$];

  task automatic model_reset();
    pc = 0; m_busy = 0; m_sel = 0; m_bank = 0; m_va = 0; m_vb = 0;
    m_la = 0; m_lb = 0; m_fa = 1; m_fb = 1; m_ca = 0; m_cb = 0;
    m_csm = 0; m_nts = 0; m_rw = 0; m_irq = 0;
    rq.delete(); dq.delete();
  endtask

  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) model_reset();
    else begin
      bit tk, acc, sa, sb;
      tk = cen && (pc == DIV - 1);
      if (cen) pc = (pc + 1) % DIV;
      acc = write;
`ifdef JTOPL_BUSY_DROP_EN
      acc = write && (m_busy == 0);
`endif
      sa = flag_A && m_fa;
      sb = flag_B && m_fb;
      if (read && !addr[0]) dq.push_back({sa || sb, sa, sb, 5'b0});
      m_irq = sa || sb;
      m_rw = 0;
      if (tk) begin m_ca = 0; m_cb = 0; end
      if (tk && m_busy > 0) m_busy--;
      if (acc && !addr[0]) begin
        m_sel = din; m_bank = addr[1]; m_busy = BA;
      end
      if (acc && addr[0]) begin
        m_busy = BD;
        if (!m_bank && m_sel == 8'h02) m_va = din;
        else if (!m_bank && m_sel == 8'h03) m_vb = din;
        else if (!m_bank && m_sel == 8'h04) begin
          if (din[7]) begin m_ca = 1; m_cb = 1; end
          else begin m_fa = !din[6]; m_fb = !din[5]; m_lb = din[1]; m_la = din[0]; end
        end else if (!m_bank && m_sel == 8'h08) begin
          m_csm = din[7]; m_nts = din[6];
        end else begin
          m_rw = 1;
          rq.push_back({m_bank, m_sel, din});
        end
      end
    end
  end

  // monitor: mid low phase, after stimulus has settled
  initial forever begin
    logic [27:0] ev, av;
    @(negedge clk);
    #2;
    ev = {m_busy != 0, cen && (pc == DIV - 1), !m_irq, m_va, m_vb, m_la, m_lb,
          m_fa, m_fb, m_ca, m_cb, m_csm, m_nts, m_rw};
    av = {busy, cen_div, irq_n, value_A, value_B, load_A, load_B,
          flagen_A, flagen_B, clr_flag_A, clr_flag_B, csm, nts, regop_wr};
    chk("state", {4'b0, av}, {4'b0, ev});
    if (regop_wr === 1'b1) begin
      if (rq.size() == 0) chk("regop_unexpected", 32'd1, 32'd0);
      else begin
        logic [16:0] e;
        e = rq.pop_front();
        chk("regop", {15'b0, regop_addr, regop_din}, {15'b0, e});
      end
    end
    while (dq.size() > 0) begin
      logic [7:0] e;
      e = dq.pop_front();
      chk("dout", {24'b0, dout}, {24'b0, e});
    end
  end

  task automatic cyc(input logic w, input logic r, input logic [1:0] a, input logic [7:0] d);
    @(negedge clk);
    write = w; read = r; addr = a; din = d;
    cen = ($urandom_range(3) != 0);
    #1;
  endtask

  task automatic idle();
    cyc(1'b0, 1'b0, 2'b00, 8'h00);
  endtask

  task automatic wait_idle();
    int n = 0;
    do begin idle(); n++; end while (busy && n < 3000);
    if (busy) chk("busy_timeout", 32'd1, 32'd0);
  endtask

  task automatic count_ticks(output int n);
    int guard = 0;
    n = 0;
    do begin
      idle(); guard++;
      if (busy && cen_div) n++;
    end while (busy && guard < 3000);
    if (busy) chk("tick_timeout", 32'd1, 32'd0);
  endtask

  initial begin
    int n;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_value_A", {24'b0, value_A}, 32'h0);
    chk("rst_flagen", {30'b0, flagen_A, flagen_B}, 32'h3);
    chk("rst_busy_irq", {30'b0, busy, irq_n}, 32'h1);
    @(negedge clk); rst_n = 1'b1;

    cyc(1'b1, 1'b0, 2'b00, 8'h02);
    count_ticks(n);
    chk("busy_ticks_addr", n, BA);
    cyc(1'b1, 1'b0, 2'b01, 8'h5A);
    count_ticks(n);
    chk("busy_ticks_data", n, BD);
    chk("value_A_5A", {24'b0, value_A}, 32'h5A);

    cyc(1'b1, 1'b0, 2'b00, 8'h04); wait_idle();
    cyc(1'b1, 1'b0, 2'b01, 8'hE3); idle();
    chk("clr_set", {28'b0, clr_flag_A, clr_flag_B, load_A | load_B, flagen_A & flagen_B}, 32'hD);
    n = 0;
    for (int i = 0; i < 200 && clr_flag_A; i++) begin
      if (cen_div) n++;
      idle();
    end
    chk("clr_one_tick", n, 1);
    wait_idle();

    cyc(1'b1, 1'b0, 2'b01, 8'h43); idle();
    chk("ctrl_43", {28'b0, load_A, load_B, flagen_A, flagen_B}, 32'hD);
    flag_A = 1'b1; idle(); idle();
    chk("irq_masked", {31'b0, irq_n}, 32'h1);
    flag_B = 1'b1; idle(); idle();
    chk("irq_asserted", {31'b0, irq_n}, 32'h0);
    cyc(1'b0, 1'b1, 2'b00, 8'h00); idle();
    chk("status_A0", {24'b0, dout}, 32'hA0);
    cyc(1'b0, 1'b1, 2'b01, 8'h00); flag_B = 1'b0; idle(); idle();
    chk("status_hold", {24'b0, dout}, 32'hA0);
    wait_idle();

    cyc(1'b1, 1'b0, 2'b10, 8'h05); wait_idle();
    cyc(1'b1, 1'b0, 2'b11, 8'h01); idle();
    chk("regop_b1", {14'b0, regop_wr, regop_addr, regop_din}, {14'b0, 1'b1, 9'h105, 8'h01});
    idle();
    chk("regop_one_clk", {31'b0, regop_wr}, 32'h0);
    wait_idle();

    cyc(1'b1, 1'b0, 2'b00, 8'h02); wait_idle();
    cyc(1'b1, 1'b0, 2'b01, 8'h11);
    cyc(1'b1, 1'b0, 2'b01, 8'h22);
    wait_idle();
`ifdef JTOPL_BUSY_DROP_EN
    chk("busy_drop", {24'b0, value_A}, 32'h11);
`else
    chk("busy_drop", {24'b0, value_A}, 32'h22);
`endif

    for (int i = 0; i < 4000; i++) begin
      logic w, r;
      logic [1:0] a;
      logic [7:0] d;
      w = ($urandom_range(4) == 0);
      r = ($urandom_range(5) == 0);
      a = 2'($urandom_range(3));
      d = 8'($urandom_range(255));
      if (w && !a[0]) begin
        case ($urandom_range(4))
          0: d = 8'h02; 1: d = 8'h03; 2: d = 8'h04; 3: d = 8'h08; default: ;
        endcase
      end
      if ($urandom_range(15) == 0) flag_A = ~flag_A;
      if ($urandom_range(15) == 0) flag_B = ~flag_B;
      cyc(w, r, a, d);
    end
    wait_idle();

    cyc(1'b1, 1'b0, 2'b01, 8'h77); idle(); idle();
    chk("busy_before_rst", {31'b0, busy}, 32'h1);
    @(negedge clk); #3; rst_n = 1'b0; #1;
    chk("async_rst_busy", {30'b0, busy, regop_wr}, 32'h0);
    idle(); idle();
    @(negedge clk); rst_n = 1'b1;
    idle(); idle();

    chk("rq_empty", rq.size(), 0);
    chk("dq_empty", dq.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
